// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sampling, debounce and key decode.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50_000,
    parameter int DEBOUNCE_SCANS = 8,
    parameter int REPEAT_DELAY   = 40,
    parameter int REPEAT_RATE    = 10
) (
    input  logic       i_CLOCK,
    input  logic       i_RESET_N,
    input  logic [3:0] i_iu_row,
    output logic [3:0] o_iu_col,
    output logic [3:0] o_KEY,
    output logic       o_KEY_VALID,
    output logic       o_KEY_HELD,
    output logic [1:0] o_dbg_state
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       row_meta_q, row_sync_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       cand_code_q, cand_code_d;
    logic [1:0]       cand_row_q, cand_row_d;
    logic [3:0]       key_q, key_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;
    logic             tick;
    logic             samp_valid;
    logic [1:0]       samp_row, samp_col;
    logic [3:0]       samp_code;
    logic [3:0]       col_rot;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    assign tick    = (div_q == DIV_W'(SCAN_DIV - 1));
    assign col_rot = {col_q[2:0], col_q[3]};
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // A sample only counts as a key when exactly one row is pulled low.
    always_comb begin
        samp_valid = 1'b1;
        samp_row   = 2'd0;
        case (row_sync_q)
            4'b1110: samp_row = 2'd0;
            4'b1101: samp_row = 2'd1;
            4'b1011: samp_row = 2'd2;
            4'b0111: samp_row = 2'd3;
            default: samp_valid = 1'b0;
        endcase
        samp_col = 2'd0;
        case (col_q)
            4'b1101: samp_col = 2'd1;
            4'b1011: samp_col = 2'd2;
            4'b0111: samp_col = 2'd3;
            default: samp_col = 2'd0;
        endcase
        samp_code = key_code(samp_row, samp_col);
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
    logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
    assign hold_inc = hold_q + HOLD_W'(1);
`endif

    always_comb begin
        div_d       = tick ? '0 : div_q + DIV_W'(1);
        state_d     = state_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        cand_code_d = cand_code_q;
        cand_row_d  = cand_row_q;
        key_d       = key_q;
        valid_d     = 1'b0;
        held_d      = held_q;
`ifdef KEYPAD_AUTOREPEAT_EN
        hold_d      = hold_q;
`endif
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (samp_valid) begin
                        cand_code_d = samp_code;
                        cand_row_d  = samp_row;
                        cnt_d       = CNT_W'(1);
                        state_d     = ST_DEBOUNCE;
                    end else begin
                        col_d = col_rot;
                    end
                end
                ST_DEBOUNCE: begin
                    if (samp_valid && samp_code == cand_code_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_d = ST_PRESSED;
                            cnt_d   = '0;
                            key_d   = cand_code_q;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            hold_d  = '0;
`endif
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_SCAN;
                        col_d   = col_rot;
                    end
                end
                ST_PRESSED: begin
                    // Only the accepted key's row matters; other rows are ignored here.
                    if (!row_sync_q[cand_row_q]) begin
                        cnt_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (hold_inc == HOLD_W'(REPEAT_DELAY)) begin
                            valid_d = 1'b1;
                            hold_d  = HOLD_W'(REPEAT_DELAY - REPEAT_RATE);
                        end else begin
                            hold_d = hold_inc;
                        end
`endif
                    end else begin
                        cnt_d = cnt_inc;
`ifdef KEYPAD_AUTOREPEAT_EN
                        hold_d = '0;
`endif
                        if (cnt_inc == CNT_MAX) begin
                            cnt_d   = '0;
                            held_d  = 1'b0;
                            state_d = ST_SCAN;
                            col_d   = col_rot;
                        end
                    end
                end
                default: begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            row_meta_q  <= 4'b1111;
            row_sync_q  <= 4'b1111;
            div_q       <= '0;
            state_q     <= ST_SCAN;
            col_q       <= 4'b1110;
            cnt_q       <= '0;
            cand_code_q <= '0;
            cand_row_q  <= '0;
            key_q       <= '0;
            valid_q     <= 1'b0;
            held_q      <= 1'b0;
        end else begin
            row_meta_q  <= i_iu_row;
            row_sync_q  <= row_meta_q;
            div_q       <= div_d;
            state_q     <= state_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            cand_code_q <= cand_code_d;
            cand_row_q  <= cand_row_d;
            key_q       <= key_d;
            valid_q     <= valid_d;
            held_q      <= held_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
        if (!i_RESET_N) hold_q <= '0;
        else            hold_q <= hold_d;
    end
`endif

    assign o_iu_col    = col_q;
    assign o_KEY       = key_q;
    assign o_KEY_VALID = valid_q;
    assign o_KEY_HELD  = held_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, directed presses, strobe scoreboard.
// Key strobes (o_KEY_VALID) are the output transactions: expected codes are queued at press time.
module tb_keypad_scanner;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int LAT      = 4 * SCAN_DIV + DEB * SCAN_DIV + 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;
  logic [1:0] dbg_state;
  logic [15:0] keys_down;

  int n_cmp;
  int n_fail;
  logic [3:0] exp_q[$];

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut (
    .i_CLOCK(clk), .i_RESET_N(rst_n), .i_iu_row(row), .o_iu_col(col),
    .o_KEY(key), .o_KEY_VALID(key_valid), .o_KEY_HELD(key_held), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // keypad matrix: a pressed key shorts its row to its column while that column is driven low
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_down[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && key_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe_key", {28'd0, key}, 32'hFFFF_FFFF);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("strobe_key", {28'd0, key}, {28'd0, e});
        check("strobe_held", {31'd0, key_held}, 32'd1);
      end
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int idx);
    @(negedge clk);
    keys_down[idx] = 1'b1;
  endtask

  task automatic release_key(input int idx);
    @(negedge clk);
    keys_down[idx] = 1'b0;
  endtask

  task automatic wait_strobes(input string name, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_release(input string name, input int limit);
    int n;
    n = 0;
    while (key_held !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, key_held}, 32'd0);
  endtask

  initial begin
    logic [3:0] col_seq[5];
    logic [3:0] c0;
    int n;
    col_seq[0] = 4'b1110; col_seq[1] = 4'b1101; col_seq[2] = 4'b1011;
    col_seq[3] = 4'b0111; col_seq[4] = 4'b1110;
    n_cmp = 0;
    n_fail = 0;
    keys_down = '0;
    rst_n = 1'b0;

    // 1. reset values and idle column rotation
    cycles(3);
    check("rst_col", col, 4'b1110);
    check("rst_key", key, 4'h0);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("idle_col%0d", k), col, col_seq[k]);
      cycles(SCAN_DIV);
    end

    // 2. stable '5', then release: held drops three ticks after release is seen
    press(5);
    exp_q.push_back(4'h5);
    wait_strobes("strobe_5_latency", LAT);
    cycles(10);
    check("held_5_pressed", key_held, 1);
    release_key(5);
    cycles(10);
    check("held_5_early", key_held, 1);
    cycles(4);
    check("held_5_dropped", key_held, 0);
    check("key_5_kept", key, 4'h5);

    // 3. bouncing 'D'
    press(15);
    cycles(SCAN_DIV);
    release_key(15);
    cycles(SCAN_DIV);
    press(15);
    exp_q.push_back(4'hD);
    wait_strobes("strobe_D", LAT + 2);
    cycles(20);
    release_key(15);
    wait_release("release_D", 20);

    // 4. rollover: '1' held, 'C' pressed meanwhile
    press(0);
    exp_q.push_back(4'h1);
    wait_strobes("strobe_1", LAT + 2);
    press(11);
    cycles(40);
    check("rollover_key", key, 4'h1);
    release_key(0);
    exp_q.push_back(4'hC);
    wait_strobes("strobe_C", 20 + LAT);
    release_key(11);
    wait_release("release_C", 20);

    // 5. two rows low on one column: no key, rotation continues
    press(0);
    press(4);
    cycles(20);
    c0 = col;
    cycles(SCAN_DIV);
    check("multi_row_rotate", col, {c0[2:0], c0[3]});
    cycles(20);
    release_key(0);
    release_key(4);
    cycles(10);

    // reset in the middle of debounce
    press(5);
    n = 0;
    while (dbg_state !== 2'd1 && n < LAT) begin
      @(negedge clk);
      n++;
    end
    check("reached_debounce", dbg_state, 2'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_col", col, 4'b1110);
    check("midrst_key", key, 4'h0);
    check("midrst_valid", key_valid, 0);
    check("midrst_held", key_held, 0);
    check("midrst_state", dbg_state, 0);
    cycles(3);
    keys_down = '0;
    cycles(2);
    rst_n = 1'b1;
    cycles(40);
    check("post_rst_key", key, 4'h0);

    // 6. hold '#' for 12 ticks after accept
    press(14);
    exp_q.push_back(4'hF);
    wait_strobes("strobe_F", LAT + 2);
`ifdef KEYPAD_AUTOREPEAT_EN
    for (int k = 0; k < 4; k++) exp_q.push_back(4'hF);
`endif
    cycles(46);
    release_key(14);
    wait_release("release_F", 20);
    check("repeat_count", exp_q.size(), 0);
    exp_q.delete();
    cycles(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
